// File: rtl/edge_mem_arbiter.sv
// ============================================================================
//  Module      : edge_mem_arbiter
//  Description : Single-port ZBT arbiter between edge-pixel writer (FIFO
//                buffered) and display read fetcher; optional write-starvation
//                guard enabled by defining EDGE_ARB_STARVE_GUARD_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_mem_arbiter #(
    parameter int ADDR_W      = 19,
    parameter int DATA_W      = 36,
    parameter int WFIFO_DEPTH = 4,
    parameter int RD_LAT      = 2,
    parameter int STARVE_MAX  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_valid_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [23:0]       wr_data_i,
    output logic              wr_ready_o,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              rd_ack_o,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int PTR_W  = $clog2(WFIFO_DEPTH);
    localparam int CNT_W  = $clog2(WFIFO_DEPTH + 1);
    localparam int PIPE_D = RD_LAT + 2;
    localparam int ENT_W  = ADDR_W + 24;

    localparam logic [1:0] G_IDLE  = 2'd0;
    localparam logic [1:0] G_READ  = 2'd1;
    localparam logic [1:0] G_WRITE = 2'd2;

    // Parameter sanity: pointer wrap relies on a power-of-two depth.
    if ((WFIFO_DEPTH < 2) || ((WFIFO_DEPTH & (WFIFO_DEPTH - 1)) != 0) ||
        (STARVE_MAX < 1) || (RD_LAT < 1) || (DATA_W < 25)) begin : g_cfg_bad
        $error("edge_mem_arbiter: unsupported parameter set");
    end

    logic [ENT_W-1:0]  fifo_q [WFIFO_DEPTH];
    logic [PTR_W-1:0]  wptr_q, rptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              fifo_full, fifo_empty, push, pop, guard_trip;
    logic [1:0]        grant;
    logic [ENT_W-1:0]  head;
    logic [PIPE_D-1:0] rd_vld_q;
    logic [DATA_W-1:0] rd_data_q, mem_wdata_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_we_q;

    assign fifo_full  = (count_q == CNT_W'(WFIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign wr_ready_o = !fifo_full;
    assign push       = wr_valid_i && !fifo_full;
    assign pop        = (grant == G_WRITE);
    assign head       = fifo_q[rptr_q];

    always_comb begin
        grant = G_IDLE;
        if (fifo_full || guard_trip) grant = G_WRITE;
        else if (rd_req_i)           grant = G_READ;
        else if (!fifo_empty)        grant = G_WRITE;
    end

    assign rd_ack_o = (grant == G_READ) && !rst_i;

`ifdef EDGE_ARB_STARVE_GUARD_EN
    localparam int GC_W = $clog2(STARVE_MAX + 1);
    logic [GC_W-1:0] starve_q, starve_d;

    assign guard_trip = !fifo_empty && (starve_q == GC_W'(STARVE_MAX));

    always_comb begin
        starve_d = starve_q;
        if ((grant == G_WRITE) || fifo_empty) starve_d = '0;
        else if (grant == G_READ)             starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) starve_q <= '0;
        else       starve_q <= starve_d;
    end
`else
    assign guard_trip = 1'b0;
`endif

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wptr_q] <= {wr_addr_i, wr_data_i};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            case (grant)
                G_READ: begin
                    mem_addr_q <= rd_addr_i;
                    mem_we_q   <= 1'b0;
                end
                G_WRITE: begin
                    mem_addr_q  <= head[ENT_W-1:24];
                    mem_wdata_q <= {{(DATA_W-24){1'b0}}, head[23:0]};
                    mem_we_q    <= 1'b1;
                end
                default: mem_we_q <= 1'b0;
            endcase
        end
    end

    // Stage RD_LAT lines up with mem_rdata of the read granted RD_LAT+1 edges ago.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_vld_q  <= '0;
            rd_data_q <= '0;
        end else begin
            rd_vld_q <= {rd_vld_q[PIPE_D-2:0], (grant == G_READ)};
            if (rd_vld_q[RD_LAT]) rd_data_q <= mem_rdata_i;
        end
    end

    assign rd_valid_o  = rd_vld_q[PIPE_D-1];
    assign rd_data_o   = rd_data_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_we_o    = mem_we_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

`default_nettype wire

// File: doc/edge_mem_arbiter.md
# edge_mem_arbiter

Arbitrates a single-port ZBT frame-buffer memory between two requesters: the edge-pixel writer and the display read fetcher. The writer streams 24-bit replicated edge pixels into a small write FIFO. The arbiter drains that FIFO into memory whenever the display side is not fetching. It sits between the edge-detect pixel path and the ZBT pins, and returns read data to the VGA side with fixed latency.

## Interface
Parameters:
- ADDR_W, 19, memory word address width
- DATA_W, 36, memory data width (pixel in bits [23:0], upper bits written 0)
- WFIFO_DEPTH, 4, write FIFO entries (power of two, ≥2)
- RD_LAT, 2, memory cycles from command on pins to mem_rdata valid
- STARVE_MAX, 8, consecutive read grants tolerated with writes pending (guard feature only)

Ports (one clock; reset is synchronous and active-high):
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wr_valid  in  1  writer has a pixel
- wr_addr  in  ADDR_W  write address
- wr_data  in  24  pixel data
- wr_ready  out  1  FIFO can accept (= not full)
- rd_req  in  1  display fetch request, held until rd_ack
- rd_addr  in  ADDR_W  fetch address
- rd_ack  out  1  fetch accepted this cycle (combinational)
- rd_valid  out  1  rd_data valid
- rd_data  out  DATA_W  fetched word
- mem_addr  out  ADDR_W  registered memory address
- mem_we  out  1  registered write enable, active-high
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  memory read data

## Operation
- Write path: a push occurs when wr_valid & wr_ready at a posedge, storing {wr_addr, wr_data}. wr_ready = (count != WFIFO_DEPTH). A push into a full FIFO is never accepted, even if a pop occurs in the same cycle.
- Grant decision each cycle (combinational, priority order):
  1. FIFO full → WRITE.
  2. Guard tripped (see Configuration) → WRITE.
  3. rd_req → READ; rd_ack=1.
  4. FIFO non-empty → WRITE.
  5. Otherwise IDLE.
- READ: mem_addr<=rd_addr, mem_we<=0.
- WRITE: pop the FIFO head; mem_addr<=head addr, mem_wdata<={12'b0, head data}, mem_we<=1.
- IDLE: mem_we<=0; mem_addr and mem_wdata hold.
- Simultaneous push and pop on a non-full FIFO: count unchanged, ordering preserved.
- Writes drain in strict FIFO order, so there is no write reordering.
- Read-after-write hazards on the same address are not detected. Callers separate frames.
- Reset values:
  - mem_we=0, mem_addr=0, mem_wdata=0
  - rd_valid=0, rd_data=0, rd_ack=0
  - wr_ready=1
  - FIFO count=0, guard counter=0
- Reset mid-operation flushes the FIFO, discards in-flight reads (rd_valid pipeline cleared) and deasserts mem_we on the next edge.

## Timing
- A grant at cycle T drives the memory pins during T+1.
- mem_rdata for a read is valid at T+1+RD_LAT. It is registered, so rd_valid=1 and rd_data are valid in cycle T+2+RD_LAT (4 cycles with defaults).
- rd_valid is a shift register of depth RD_LAT+2. Back-to-back reads give back-to-back rd_valid.
- Maximum throughput is one memory operation per cycle.
- Write latency from push to mem_we is at least 2 cycles (push edge, then grant edge).

## Configuration
- Macro: EDGE_ARB_STARVE_GUARD_EN.
- With the macro defined:
  - A counter increments on each READ grant while the FIFO is non-empty.
  - It clears on any WRITE grant or when the FIFO is empty.
  - When the counter equals STARVE_MAX, the next decision is forced to WRITE and rd_ack=0 that cycle.
- Without the macro: the counter is absent and writes preempt reads only when the FIFO is full (rule 1).

## Test plan
- Reset, then idle: mem_we=0, mem_addr=0, wr_ready=1, rd_valid=0 for 10 cycles.
- Single read of address 0x00010 with mem model returning 0x123456 → rd_ack in the request cycle; rd_valid=1 and rd_data=0x000123456 exactly 4 cycles later.
- Push 4 pixels (addr 0–3, data 0xFFFFFF/0x0) with rd_req held high → wr_ready=0 after the 4th push; the full FIFO forces 1 write; mem writes appear in order 0,1,2,3.
- Push and pop in the same cycle with count=2 → count stays 2; no pixel lost across 100 random cycles (scoreboard).
- Guard enabled, STARVE_MAX=8, continuous rd_req with 1 pending write → 8 read grants, then mem_we=1 with rd_ack=0, then reads resume. Guard disabled: no write until the FIFO is full.
- Assert reset with 3 reads in flight and 2 FIFO entries → no rd_valid afterwards, mem_we=0, wr_ready=1.
